// File: rtl/fetch_stall_responder.sv
// ---------------------------------------------------------------------------
// fetch_stall_responder
//
// Fetch stage at the consumer end of the stall handshake. It owns the PC and
// drives the synchronous program memory (PM). It also loads the IF/ID register.
//   - On stall, the PC is frozen and NOP bubbles are pushed into IF/ID.
//   - When stall_pm is raised, the PM output is stale. In that case the word
//     captured when the stall began is replayed instead of the PM output.
//   - A taken branch redirects the PC and refills the pipe through S_BOOT.
//   - A HALT opcode stops fetch until reset.
//   - An 8-bit counter counts stall cycles and saturates at 8'hFF.
//
// Ports
//   clk_i            rising-edge clock
//   reset_i          asynchronous, active-high reset
//   stall_i          hold PC, bubble IF/ID
//   stall_pm_i       PM read data is stale, use the held word
//   branch_taken_i   redirect the PC this cycle
//   branch_target_i  redirect address
//   pm_instr_i       PM read data (one cycle after pm_addr_o)
//   pm_addr_o        PM word address (the PC register)
//   pm_en_o          PM read enable
//   ifid_instr_o     IF/ID instruction
//   ifid_pc_o        address of ifid_instr_o
//   ifid_valid_o     1 = real instruction, 0 = bubble
//   halted_o         1 while fetch is halted
//   stall_cnt_o      saturating count of stall cycles since reset
// ---------------------------------------------------------------------------
module fetch_stall_responder #(
  parameter int                   ADDR_W   = 16,
  parameter int                   INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [INSTR_W-1:0]   NOP      = '0,
  parameter logic [5:0]           HALT_OP  = 6'b111111
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               stall_i,
  input  logic               stall_pm_i,
  input  logic               branch_taken_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic [INSTR_W-1:0] pm_instr_i,
  output logic [ADDR_W-1:0]  pm_addr_o,
  output logic               pm_en_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [ADDR_W-1:0]  ifid_pc_o,
  output logic               ifid_valid_o,
  output logic               halted_o,
  output logic [7:0]         stall_cnt_o
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_RUN,
    S_STALL,
    S_REPLAY,
    S_HALT
  } state_t;

  state_t             state_q,      state_d;
  logic [ADDR_W-1:0]  pc_q,         pc_d;
  logic [ADDR_W-1:0]  fetch_pc_q,   fetch_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_q,    ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] instr_hold_q, instr_hold_d;
  logic               halted_q,     halted_d;
  logic [7:0]         stall_cnt_q,  stall_cnt_d;
  logic               stall_prev_q, stall_prev_d;

  logic               pm_en;
  logic [INSTR_W-1:0] sel_instr;
  logic [5:0]         sel_opcode;

  assign pm_en      = ~stall_i & ~halted_q;
  assign sel_instr  = stall_pm_i ? instr_hold_q : pm_instr_i;
  assign sel_opcode = sel_instr[INSTR_W-1 -: 6];

  // Next-state logic for the whole fetch stage.
  // fetch_pc follows the PC only on cycles when the PM actually reads. As a
  // result, it always names the word that pm_instr (or the held copy) holds.
  // This keeps the replayed word labelled with its own address after a stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    instr_hold_d = instr_hold_q;
    halted_d     = halted_q;
    stall_cnt_d  = stall_cnt_q;
    stall_prev_d = stall_i;

    // Capture the last good PM word on the first stall cycle.
    if (stall_i && !stall_prev_q) begin
      instr_hold_d = pm_instr_i;
    end

    if (pm_en) begin
      fetch_pc_d = pc_q;
    end

    if (state_q == S_HALT) begin
      // The halt word stays visible one cycle, then becomes a bubble.
      ifid_valid_d = 1'b0;
    end else if (branch_taken_i) begin
      pc_d         = branch_target_i;
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
      state_d      = S_BOOT;
    end else if (stall_i) begin
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
      if (stall_cnt_q != 8'hFF) begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
      state_d = S_STALL;
    end else if (state_q == S_BOOT) begin
      // The first PM read of a refill is still in flight.
      pc_d         = pc_q + ADDR_W'(1);
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
      state_d      = S_RUN;
    end else begin
      pc_d         = pc_q + ADDR_W'(1);
      ifid_instr_d = sel_instr;
      ifid_pc_d    = fetch_pc_q;
      ifid_valid_d = 1'b1;
      if (sel_opcode == HALT_OP) begin
        halted_d = 1'b1;
        state_d  = S_HALT;
      end else if (state_q == S_STALL && stall_pm_i) begin
        state_d = S_REPLAY;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  // Single state register for the stage. Reset clears everything at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      ifid_instr_q <= NOP;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      instr_hold_q <= NOP;
      halted_q     <= 1'b0;
      stall_cnt_q  <= 8'h00;
      stall_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      instr_hold_q <= instr_hold_d;
      halted_q     <= halted_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_prev_q <= stall_prev_d;
    end
  end

  assign pm_addr_o    = pc_q;
  assign pm_en_o      = pm_en;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_valid_o = ifid_valid_q;
  assign halted_o     = halted_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stall_responder.sv
// ---------------------------------------------------------------------------
// tb_fetch_stall_responder
//
// Directed bench for fetch_stall_responder. The bench contains a small
// synchronous PM model where PM[a] = 0x100 + a. The PM output is not held
// while the PM is disabled. A HALT word at address 7 can be switched in when
// needed. All inputs change, and all outputs are sampled, 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_stall_responder;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               reset;
  logic               stall;
  logic               stallPm;
  logic               branchTaken;
  logic [ADDR_W-1:0]  branchTarget;
  logic [INSTR_W-1:0] pmInstr;
  logic [ADDR_W-1:0]  pmAddr;
  logic               pmEn;
  logic [INSTR_W-1:0] ifidInstr;
  logic [ADDR_W-1:0]  ifidPc;
  logic               ifidValid;
  logic               halted;
  logic [7:0]         stallCnt;

  int   total = 0;
  int   bad   = 0;
  logic haltEnable = 1'b0;

  fetch_stall_responder dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .stall_i         (stall),
    .stall_pm_i      (stallPm),
    .branch_taken_i  (branchTaken),
    .branch_target_i (branchTarget),
    .pm_instr_i      (pmInstr),
    .pm_addr_o       (pmAddr),
    .pm_en_o         (pmEn),
    .ifid_instr_o    (ifidInstr),
    .ifid_pc_o       (ifidPc),
    .ifid_valid_o    (ifidValid),
    .halted_o        (halted),
    .stall_cnt_o     (stallCnt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pmWord(input logic [ADDR_W-1:0] a);
    if (haltEnable && a == 16'd7) return 32'hFC00_0107;
    return 32'h0000_0100 + 32'(a);
  endfunction

  // Synchronous PM: one cycle read latency, output is garbage while disabled
  always @(posedge clk) begin
    if (pmEn) pmInstr <= pmWord(pmAddr);
    else      pmInstr <= 32'hDEAD_BEEF;
  end

  // Safety net in case the run ever stops advancing
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic sp, input logic br,
                               input logic [ADDR_W-1:0] tgt);
    stall        = s;
    stallPm      = sp;
    branchTaken  = br;
    branchTarget = tgt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check one valid IF/ID word plus the PC that should follow it
  task automatic checkFetch(input string tag, input logic [31:0] instr,
                            input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] nextAddr);
    checkOutput({tag, ".valid"}, 32'(ifidValid), 32'd1);
    checkOutput({tag, ".instr"}, ifidInstr, instr);
    checkOutput({tag, ".pc"}, 32'(ifidPc), 32'(pc));
    checkOutput({tag, ".addr"}, 32'(pmAddr), 32'(nextAddr));
  endtask

  task automatic checkBubble(input string tag, input logic [ADDR_W-1:0] nextAddr);
    checkOutput({tag, ".valid"}, 32'(ifidValid), 32'd0);
    checkOutput({tag, ".addr"}, 32'(pmAddr), 32'(nextAddr));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();

    // Reset state
    checkOutput("rst.addr",  32'(pmAddr),    32'h0);
    checkOutput("rst.valid", 32'(ifidValid), 32'h0);
    checkOutput("rst.instr", ifidInstr,      32'h0);
    checkOutput("rst.pc",    32'(ifidPc),    32'h0);
    checkOutput("rst.halt",  32'(halted),    32'h0);
    checkOutput("rst.cnt",   32'(stallCnt),  32'h0);
    checkOutput("rst.pmen",  32'(pmEn),      32'h1);

    // Free run from reset: one boot bubble, then 0x100@0, 0x101@1, ...
    reset = 1'b0;
    tick();
    checkBubble("boot", 16'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkFetch($sformatf("run%0d", k), 32'h100 + k, 16'(k), 16'(k + 2));
    end

    // Two-cycle stall at pc=5, stall_pm on the cycle after release
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    #1;
    checkOutput("stl.pmen", 32'(pmEn), 32'h0);
    tick();
    checkBubble("stl1", 16'd5);
    checkOutput("stl1.cnt", 32'(stallCnt), 32'd1);
    tick();
    checkBubble("stl2", 16'd5);
    checkOutput("stl2.cnt", 32'(stallCnt), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    tick();
    checkFetch("replay", 32'h104, 16'd4, 16'd6);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkFetch("post1", 32'h105, 16'd5, 16'd7);
    tick();
    checkFetch("post2", 32'h106, 16'd6, 16'd8);

    // Branch asserted together with stall: branch wins, counter untouched
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0020);
    tick();
    checkBubble("br1", 16'h0020);
    checkOutput("br1.cnt", 32'(stallCnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkBubble("br2", 16'h0021);
    tick();
    checkFetch("brtgt", 32'h120, 16'h0020, 16'h0022);
    checkOutput("brtgt.cnt", 32'(stallCnt), 32'd2);

    // Long stall: counter saturates at 8'hFF
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 252; i++) tick();
    checkOutput("sat.fe", 32'(stallCnt), 32'hFE);
    tick();
    checkOutput("sat.ff", 32'(stallCnt), 32'hFF);
    for (int i = 0; i < 47; i++) tick();
    checkOutput("sat.hold", 32'(stallCnt), 32'hFF);
    checkBubble("sat", 16'h0022);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    tick();
    checkFetch("satrel", 32'h121, 16'h0021, 16'h0023);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkFetch("satrel2", 32'h122, 16'h0022, 16'h0024);

    // PC wrap through 16'hFFFF
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE);
    tick();
    checkBubble("wr.br", 16'hFFFE);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkBubble("wr.boot", 16'hFFFF);
    tick();
    checkFetch("wr.fffe", 32'h100FE, 16'hFFFE, 16'h0000);
    tick();
    checkFetch("wr.ffff", 32'h100FF, 16'hFFFF, 16'h0001);
    tick();
    checkFetch("wr.0000", 32'h100, 16'h0000, 16'h0002);

    // Async reset in the middle of a stall, checked before the next edge
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("ar.cnt0", 32'(stallCnt), 32'hFF);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar.addr",  32'(pmAddr),    32'h0);
    checkOutput("ar.valid", 32'(ifidValid), 32'h0);
    checkOutput("ar.instr", ifidInstr,      32'h0);
    checkOutput("ar.pc",    32'(ifidPc),    32'h0);
    checkOutput("ar.cnt",   32'(stallCnt),  32'h0);
    checkOutput("ar.halt",  32'(halted),    32'h0);

    // HALT opcode at address 7
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    haltEnable = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checkBubble("h.boot", 16'd1);
    for (int k = 0; k < 7; k++) begin
      tick();
      checkFetch($sformatf("h.run%0d", k), 32'h100 + k, 16'(k), 16'(k + 2));
    end
    tick();
    checkFetch("h.word", 32'hFC00_0107, 16'd7, 16'd9);
    checkOutput("h.halted", 32'(halted), 32'd1);
    checkOutput("h.pmen",   32'(pmEn),   32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0030);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkBubble($sformatf("h.frz%0d", i), 16'd9);
      checkOutput("h.frz.pc",    32'(ifidPc),   32'd7);
      checkOutput("h.frz.instr", ifidInstr,     32'hFC00_0107);
      checkOutput("h.frz.halt",  32'(halted),   32'd1);
      checkOutput("h.frz.cnt",   32'(stallCnt), 32'd0);
    end
    reset = 1'b1;
    #1;
    checkOutput("h.rst.halt", 32'(halted), 32'd0);
    checkOutput("h.rst.addr", 32'(pmAddr), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    checkBubble("h.reboot", 16'd1);
    tick();
    checkFetch("h.refetch", 32'h100, 16'd0, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
